gpr_wb_queue: RTL

- Writer-side companion to the GPR register file; sits between the pipeline's writeback sources and the GPR write port (write-enable, write address, write data).
- Buffers writeback requests in a small in-order FIFO and drains one write per cycle.
- Provides forwarding of still-pending writes to the two decode-stage read addresses, so reads never see stale GPR contents.
- Drives the GPR write port from registered state, so values are stable before the GPR's negedge write.

---
 rtl/gpr_wb_queue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gpr_wb_queue.sv
// gpr_wb_queue: in-order writeback buffer in front of the GPR write port, with read forwarding.
// Latency: an entry captured at posedge N can drive gpr_we in cycle N+1 (at the earliest).
// Backpressure: in_ready=0 when full (a coalescing request is still taken); wb_hold freezes draining.
// Optional feature macro: GPR_WB_COALESCE_EN (merge a request into the youngest entry with the same register).
module gpr_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_reg,
  input  logic [DW-1:0] in_data,
  input  logic          wb_hold,
  output logic          gpr_we,
  output logic [AW-1:0] gpr_waddr,
  output logic [DW-1:0] gpr_wdata,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          fwd_hit1,
  output logic [DW-1:0] fwd_data1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data2,
  output logic [CW-1:0] count,
  output logic          empty
);

  // Entry storage, circular buffer indexed by rd_ptr/wr_ptr.
  logic [AW-1:0] reg_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Last values driven on the write port; held while idle or on hold.
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [DW-1:0] last_data_q, last_data_d;

  logic empty_w;
  logic drain;
  logic coalesce;
  logic accept;
  logic alloc;

  assign empty_w = (count_q == '0);
  assign drain   = !empty_w && !wb_hold;

`ifdef GPR_WB_COALESCE_EN
  logic [PW-1:0] youngest;
  assign youngest = wr_ptr_q - 1'b1;

  // Merge into the youngest entry, unless that entry is the head leaving this cycle.
  always_comb begin
    coalesce = 1'b0;
    if (in_valid && (in_reg != '0) && !empty_w && (reg_q[youngest] == in_reg) &&
        !(drain && (count_q == CW'(1)))) begin
      coalesce = 1'b1;
    end
  end
`else
  assign coalesce = 1'b0;
`endif

  // Capacity check ignores a same-cycle pop; a merge needs no new slot.
  assign in_ready = (count_q < CW'(DEPTH)) || coalesce;
  assign accept   = in_valid && in_ready;
  // r0 requests are consumed but never stored.
  assign alloc    = accept && (in_reg != '0) && !coalesce;

  // Next-state for pointers, occupancy and held write-port values.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (alloc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (drain) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      last_addr_d = reg_q[rd_ptr_q];
      last_data_d = data_q[rd_ptr_q];
    end
    case ({alloc, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset; discards all pending entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // Entry write: new allocation at the tail, or data merge into the youngest entry.
  always_ff @(posedge clk) begin
    if (rst_n && alloc) begin
      reg_q[wr_ptr_q]  <= in_reg;
      data_q[wr_ptr_q] <= in_data;
    end
`ifdef GPR_WB_COALESCE_EN
    else if (rst_n && accept && coalesce) begin
      data_q[youngest] <= in_data;
    end
`endif
  end

  // Write port: head entry while draining, otherwise the last driven values.
  always_comb begin
    gpr_we    = drain;
    gpr_waddr = last_addr_q;
    gpr_wdata = last_data_q;
    if (drain) begin
      gpr_waddr = reg_q[rd_ptr_q];
      gpr_wdata = data_q[rd_ptr_q];
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overrides; head included.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if ((rd_addr1 != '0) && (reg_q[idx] == rd_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if ((rd_addr2 != '0) && (reg_q[idx] == rd_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end

  assign count = count_q;
  assign empty = empty_w;

endmodule
